// File: rtl/mio_uart_pkg.sv
// Shared types and constants for the MIO UART transmitter: serialiser states,
// status word layout and the control-write flag position.
package mio_uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;

   localparam int ST_COUNT_LSB = 0;
   localparam int ST_COUNT_W   = 4;
   localparam int ST_EMPTY     = 4;
   localparam int ST_FULL      = 5;
   localparam int ST_BUSY      = 6;
   localparam int ST_OVF       = 7;

   localparam int CTRL_BIT     = 31;

   function automatic logic [31:0] pack_status(
      input logic                  ovf,
      input logic                  busy,
      input logic                  full,
      input logic                  empty,
      input logic [ST_COUNT_W-1:0] cnt
   );
      logic [31:0] s;
      s = '0;
      s[ST_COUNT_LSB +: ST_COUNT_W] = cnt;
      s[ST_EMPTY]                   = empty;
      s[ST_FULL]                    = full;
      s[ST_BUSY]                    = busy;
      s[ST_OVF]                     = ovf;
      return s;
   endfunction

endpackage

// File: rtl/mio_uart_tx_if.sv
// Bus-side connection of the UART transmitter: write strobe/data from the
// decoder, status word and completion interrupt back to the CPU side.
interface mio_uart_tx_if;
   logic        uart_we;
   logic [31:0] P_Data;
   logic [31:0] status;
   logic        irq;

   modport master (output uart_we, output P_Data, input status, input irq);
   modport slave  (input uart_we, input P_Data, output status, output irq);
endinterface

// File: rtl/mio_uart_tx_sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count; the head entry is
// visible combinationally so the consumer can take it on the pop edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // Qualification uses the pre-edge count, so a push on full is lost even
   // when a pop frees a slot on the same edge.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: buffers CPU bytes in a FIFO, serialises
// them LSB first on tx, reports status and pulses irq when fully drained.
module mio_uart_tx #(
   parameter int BAUD_DIV   = 868,
   parameter int FIFO_DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   mio_uart_tx_if.slave  bus,
   output logic          tx
);
   import mio_uart_pkg::*;

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   uart_state_e state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        fin_q, fin_d;
   logic        irq_q;
   logic        ovf_q, ovf_d;

   logic          wr_data;
   logic          wr_ctrl;
   logic          push;
   logic          pop;
   logic          tick;
   logic [7:0]    fifo_head;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          unused_pdata;

   assign wr_data      = bus.uart_we && !bus.P_Data[CTRL_BIT];
   assign wr_ctrl      = bus.uart_we &&  bus.P_Data[CTRL_BIT];
   assign push         = wr_data && !fifo_full;
   assign unused_pdata = ^bus.P_Data[30:8];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (bus.P_Data[7:0]),
      .pop_i   (pop),
      .dout_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      ovf_d = ovf_q;
      if (wr_ctrl)                      ovf_d = 1'b0;
      else if (wr_data && fifo_full)    ovf_d = 1'b1;
   end

   assign tick = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      fin_d   = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_head;
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            tx_d   = 1'b0;
            baud_d = tick ? '0 : baud_q + 16'd1;
            if (tick) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            tx_d   = shift_q[0];
            baud_d = tick ? '0 : baud_q + 16'd1;
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         S_STOP: begin
            baud_d = tick ? '0 : baud_q + 16'd1;
            if (tick) begin
               // Chain straight into the next start bit when more data waits.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_head;
                  state_d = S_START;
               end else begin
                  fin_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // tx and irq are retimed one cycle behind the state so the line is glitch
   // free; fin_q then delays irq to sit just after the stop bit on the wire.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         fin_q   <= 1'b0;
         irq_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         fin_q   <= fin_d;
         irq_q   <= fin_q;
         ovf_q   <= ovf_d;
      end
   end

   assign tx         = tx_q;
   assign bus.irq    = irq_q;
   assign bus.status = pack_status(ovf_q, (state_q != S_IDLE), fifo_full,
                                   fifo_empty, ST_COUNT_W'(fifo_count));

endmodule

// File: tb/tb_mio_uart_tx.sv
// Randomised and directed bench for mio_uart_tx against a queue-and-countdown
// reference model of the transmitter's observable behaviour.
module tb_mio_uart_tx;
   localparam int BAUD  = 4;
   localparam int DEPTH = 8;
   localparam int FRAME = 10 * BAUD;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx;

   always #5 clk = ~clk;

   mio_uart_tx_if bus_if ();

   mio_uart_tx #(
      .BAUD_DIV   (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if),
      .tx  (tx)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: queued bytes, whether a frame is on the wire, edges left
   // in it, byte being sent, sticky overflow and a pending drain event.
   logic [7:0] q[$];
   bit         mbusy = 1'b0;
   bit         movf  = 1'b0;
   bit         mfin  = 1'b0;
   int         mleft = 0;
   logic [7:0] mcur  = 8'h00;
   logic       exp_tx;
   logic       exp_irq;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s      = '0;
      s[3:0] = 4'(q.size());
      s[4]   = (q.size() == 0);
      s[5]   = (q.size() == DEPTH);
      s[6]   = mbusy;
      s[7]   = movf;
      return s;
   endfunction

   task automatic model_edge();
      bit full, frame_end, do_pop, new_fin;
      int pos;
      if (rst) begin
         q.delete();
         mbusy   = 1'b0;
         movf    = 1'b0;
         mfin    = 1'b0;
         mleft   = 0;
         exp_tx  = 1'b1;
         exp_irq = 1'b0;
      end else begin
         if (!mbusy) exp_tx = 1'b1;
         else begin
            pos = (FRAME - mleft) / BAUD;
            if (pos == 0)      exp_tx = 1'b0;
            else if (pos <= 8) exp_tx = mcur[pos-1];
            else               exp_tx = 1'b1;
         end
         exp_irq   = mfin;
         full      = (q.size() == DEPTH);
         frame_end = mbusy && (mleft == 1);
         do_pop    = (q.size() > 0) && (!mbusy || frame_end);
         new_fin   = frame_end && (q.size() == 0);
         if (do_pop) begin
            mcur  = q.pop_front();
            mbusy = 1'b1;
            mleft = FRAME;
         end else if (frame_end) begin
            mbusy = 1'b0;
         end else if (mbusy) begin
            mleft--;
         end
         if (bus_if.uart_we) begin
            if (bus_if.P_Data[31]) movf = 1'b0;
            else if (full)         movf = 1'b1;
            else                   q.push_back(bus_if.P_Data[7:0]);
         end
         mfin = new_fin;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("tx", 32'(tx), 32'(exp_tx));
      check_eq("irq", 32'(bus_if.irq), 32'(exp_irq));
      check_eq("status", bus_if.status, exp_status());
   endtask

   task automatic drive(input logic we, input logic [31:0] d, input logic r);
      bus_if.uart_we = we;
      bus_if.P_Data  = d;
      rst            = r;
      step();
      bus_if.uart_we = 1'b0;
      bus_if.P_Data  = '0;
      rst            = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((bus_if.status[6] || !bus_if.status[4]) && n < budget) begin
         drive(1'b0, '0, 1'b0);
         n++;
      end
      check_eq(tag, 32'({bus_if.status[6], bus_if.status[4]}), 32'(2'b01));
      repeat (3) drive(1'b0, '0, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n, first_low, irqs, lows;
      logic [3:0] cnt_before;
      bus_if.uart_we = 1'b0;
      bus_if.P_Data  = '0;

      // Reset and idle hold
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);
      check_eq("reset_status", bus_if.status, 32'h10);
      check_eq("reset_tx", 32'(tx), 32'd1);
      repeat (1000) drive(1'b0, '0, 1'b0);
      $display("idle hold: 1000 cycles, checks=%0d", checks);

      // Single byte 0x55
      drive(1'b1, 32'h55, 1'b0);
      n = 0; first_low = -1;
      while (!bus_if.irq && n < 100) begin
         step();
         n++;
         if (tx == 1'b0 && first_low < 0) first_low = n;
      end
      check_eq("sb_tx_low_at", 32'(first_low), 32'd2);
      check_eq("sb_irq_at", 32'(n), 32'd42);
      step();
      check_eq("sb_irq_width", 32'(bus_if.irq), 32'd0);
      check_eq("sb_status_end", bus_if.status, 32'h10);
      $display("single byte 0x55: irq after %0d cycles", n);

      // Back-to-back frames
      drive(1'b1, 32'hA5, 1'b0);
      drive(1'b1, 32'h3C, 1'b0);
      drive(1'b1, 32'hFF, 1'b0);
      check_eq("b2b_count", 32'(bus_if.status[3:0]), 32'd2);
      irqs = 0; n = 0;
      while (n < 3 * FRAME + 20) begin
         step();
         n++;
         if (bus_if.irq) irqs++;
      end
      check_eq("b2b_irq_count", 32'(irqs), 32'd1);
      $display("back-to-back A5 3C FF: irqs=%0d", irqs);

      // Overflow on ten writes
      for (int i = 0; i < 10; i++) drive(1'b1, 32'(8'h10 + i), 1'b0);
      check_eq("ovf_set", 32'(bus_if.status[7]), 32'd1);
      check_eq("ovf_full", 32'(bus_if.status[5]), 32'd1);
      cnt_before = bus_if.status[3:0];
      drive(1'b1, 32'h8000_0000, 1'b0);
      check_eq("ovf_clear", 32'(bus_if.status[7]), 32'd0);
      check_eq("ovf_clear_count", 32'(bus_if.status[3:0]), 32'(cnt_before));
      drain("ovf_drain", 12 * FRAME);
      $display("overflow: 10 writes, count before clear=%0d", cnt_before);

      // Push on full coinciding with the STOP->START pop
      for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 32'(8'hC0 + i), 1'b0);
      n = 0;
      while (!(mbusy && mleft == 1 && q.size() == DEPTH) && n < 2 * FRAME) begin
         drive(1'b0, '0, 1'b0);
         n++;
      end
      check_eq("pof_full_before", 32'(bus_if.status[5]), 32'd1);
      drive(1'b1, 32'h77, 1'b0);
      check_eq("pof_ovf", 32'(bus_if.status[7]), 32'd1);
      check_eq("pof_count", 32'(bus_if.status[3:0]), 32'(DEPTH - 1));
      drive(1'b1, 32'h8000_0000, 1'b0);
      drain("pof_drain", 12 * FRAME);
      $display("push on full with pop: count=%0d", DEPTH - 1);

      // Reset during data bit 3 with two bytes queued
      drive(1'b1, 32'h96, 1'b0);
      drive(1'b1, 32'h5A, 1'b0);
      drive(1'b1, 32'hE1, 1'b0);
      n = 0;
      while (!(mbusy && ((FRAME - mleft) / BAUD) == 4) && n < FRAME) begin
         drive(1'b0, '0, 1'b0);
         n++;
      end
      check_eq("mid_tx_low_before", 32'(bus_if.status[6]), 32'd1);
      drive(1'b0, '0, 1'b1);
      check_eq("mid_rst_tx", 32'(tx), 32'd1);
      check_eq("mid_rst_status", bus_if.status, 32'h10);
      irqs = 0; lows = 0;
      repeat (3 * FRAME) begin
         drive(1'b0, '0, 1'b0);
         if (bus_if.irq) irqs++;
         if (!tx) lows++;
      end
      check_eq("mid_no_irq", 32'(irqs), 32'd0);
      check_eq("mid_no_frame", 32'(lows), 32'd0);
      $display("reset mid-frame: irqs=%0d tx_lows=%0d", irqs, lows);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 10)
            drive(1'b1, {1'b0, 23'($urandom), 8'($urandom)}, 1'b0);
         else if (r == 10)
            drive(1'b1, {1'b1, 31'($urandom)}, 1'b0);
         else if (r == 11 && $urandom_range(0, 9) == 0)
            drive(1'b0, '0, 1'b1);
         else
            drive(1'b0, '0, 1'b0);
      end
      drain("rand_drain", 12 * FRAME);
      $display("random traffic: 3000 cycles, checks=%0d", checks);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mio_uart_tx.md
# mio_uart_tx

Memory-mapped UART transmitter on the MIO peripheral bus, downstream of the bus decoder alongside the LED/counter peripherals. The CPU writes bytes through the bus peripheral-data path. The block buffers them in a small FIFO and serialises each as an 8N1 frame on `tx`. It returns a status word for the bus read mux and raises a one-cycle completion interrupt.

## Interface
- `BAUD_DIV`, default 868: clocks per bit (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, 2..8.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `uart_we` input 1: bus write strobe decoded for this peripheral; one write per cycle high.
- `P_Data` input 32: peripheral write data from the bus.
- `tx` output 1: serial line, idle high.
- `status` output 32: read-back word `{24'b0, overflow, busy, full, empty, count[3:0]}`.
- `irq` output 1: one-cycle pulse when transmission drains completely.

## Operation
- Write decode is qualified by `uart_we`.
  - `P_Data[31]=0` is a data write: push `P_Data[7:0]` if not full.
  - If the FIFO is full, the byte is dropped and sticky `overflow` is set.
  - `P_Data[31]=1` is a control write: clear `overflow`; nothing is pushed; other bits are ignored.
- Full is judged on pre-edge count. A write while full is dropped even if a pop happens on the same edge.
- A push and a pop on the same edge leave `count` unchanged.
- FSM states and transitions:
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
  - START: `tx=0` for `BAUD_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift bit, LSB first, `BAUD_DIV` cycles per bit. After bit 7, go to STOP.
  - STOP: `tx=1` for `BAUD_DIV` cycles. At the end of STOP:
    - FIFO non-empty: pop and go to START directly, with no idle gap.
    - FIFO empty: go to IDLE and pulse `irq`.
- Baud counter counts 0..`BAUD_DIV`-1. A bit boundary occurs when the counter equals `BAUD_DIV`-1; the counter then wraps to 0.
- Bit index counts 0..7 inside DATA.
- `busy`=1 in any state other than IDLE.
- Status bits:
  - `empty` = (`count`==0).
  - `full` = (`count`==`FIFO_DEPTH`).
  - `count` is zero-extended to 4 bits.
- Reset values: `tx`=1, `irq`=0, `count`=0, `empty`=1, `full`=0, `busy`=0, `overflow`=0, state IDLE.
- Reset mid-frame: the frame is aborted, `tx` returns high on the next edge, and FIFO contents are discarded. Only a full frame is guaranteed; no partial-frame completion.

## Timing
- A write sampled at edge E into an empty FIFO with IDLE state gives `count`=1 after E.
- The pop occurs at E+1; `tx` is low from E+2.
- Frame length is exactly 10×`BAUD_DIV` cycles, measured from the falling start edge to the end of the stop bit.
- Back-to-back frames are contiguous: the next start bit begins the cycle after the stop bit ends.
- `irq` is high for exactly the one cycle after the final stop bit's last clock. It is not asserted at reset.
- `status` is registered state, valid one cycle after the causing edge, with no combinational path from `uart_we`.
- `overflow` set and clear in the same cycle cannot occur, because one write is accepted per cycle.

## Structure
- Package `mio_uart_pkg` holds:
  - state enum (IDLE, START, DATA, STOP);
  - status bit index constants (`ST_COUNT_LSB`=0, `ST_EMPTY`=4, `ST_FULL`=5, `ST_BUSY`=6, `ST_OVF`=7);
  - the control-write bit constant (31).
- One sub-module, `sync_fifo`: parameterised width/depth, synchronous push/pop, registered count, full/empty outputs. Same `clk`/`rst` as the parent.
- Serialiser FSM, baud counter and status/irq logic live in the parent.

## Test plan
- Single byte: `BAUD_DIV`=4, write 0x55 at edge E.
  - `tx` low from E+2 for 4 cycles, then the pattern 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high.
  - `irq` pulses once at E+42; `status` returns to 0x10.
- Back-to-back: write 0xA5, 0x3C, 0xFF on consecutive cycles.
  - Three contiguous 40-cycle frames with no idle gap.
  - `count` reads 2 after the third write.
  - Exactly one `irq`, after the third frame.
- Overflow: `FIFO_DEPTH`=8, 10 consecutive data writes.
  - 9 bytes are transmitted in order; the 10th is dropped.
  - `status[7]`=1 and `status[5]`=1 while full.
  - A control write of 0x8000_0000 clears bit 7 without changing `count`.
- Reset mid-frame: assert `rst` during DATA bit 3 with 2 bytes queued.
  - `tx`=1 on the next edge and `status`=0x10.
  - No `irq`, no further frames.
- Push on full with simultaneous pop: fill the FIFO, then write exactly on the STOP→START pop edge.
  - The byte is dropped, `overflow`=1, and `count` decrements by 1.
- Idle hold: no writes for 1000 cycles after reset → `tx`=1, `irq`=0, `status`=0x10 throughout.
